// File: rtl/tree_pipe.sv
// Pipelined heap-indexed decision-tree traversal: one tree level per stage, falling-edge registers,
// with per-stage valid/done tracking, global stall (en), synchronous flush and early leaf termination.
module tree_pipe #(
    parameter int DEPTH  = 10,
    parameter int NODE_W = 11
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          flush,
    input  logic                          in_valid,
    input  logic [DEPTH-1:0]              next_branch,
    input  logic [DEPTH-1:0]              is_leaf,
    output logic [(DEPTH-1)*NODE_W-1:0]   next_feature,
    output logic [DEPTH-1:0]              stage_valid,
    output logic                          out_valid,
    output logic                          out_early,
    output logic [NODE_W-1:0]             result_node,
    output logic [DEPTH-1:0]              result_index
);

    // First heap index of the leaf level, 2^DEPTH - 1.
    localparam logic [NODE_W-1:0] LEAF_BASE = {{(NODE_W-DEPTH){1'b0}}, {DEPTH{1'b1}}};

    logic [NODE_W-1:0] node_q [DEPTH];
    logic [NODE_W-1:0] node_d [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  done_q, done_d;
    logic [NODE_W-1:0] leaf_offset;

    // The last level is always a leaf, so its leaf flag carries no information.
    logic unused_last_leaf;
    assign unused_last_leaf = is_leaf[DEPTH-1];

    // Next-state for every stage: descend one level unless the sample already hit a leaf.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            node_d[k] = node_q[k];
        end
        valid_d = valid_q;
        done_d  = done_q;

        valid_d[0] = in_valid & ~flush;
        if (!in_valid) begin
            node_d[0] = '0;
            done_d[0] = 1'b0;
        end else if (is_leaf[0]) begin
            node_d[0] = '0;
            done_d[0] = 1'b1;
        end else begin
            node_d[0] = NODE_W'(1) + NODE_W'(next_branch[0]);
            done_d[0] = 1'b0;
        end

        for (int k = 1; k < DEPTH; k++) begin
            valid_d[k] = valid_q[k-1] & ~flush;
            if (done_q[k-1]) begin
                node_d[k] = node_q[k-1];
                done_d[k] = 1'b1;
            end else if ((k < DEPTH-1) && is_leaf[k]) begin
                node_d[k] = node_q[k-1];
                done_d[k] = 1'b1;
            end else begin
                node_d[k] = (node_q[k-1] << 1) + NODE_W'(1) + NODE_W'(next_branch[k]);
                done_d[k] = 1'b0;
            end
        end

        if (flush) begin
            valid_d = '0;
            done_d  = '0;
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                node_q[k] <= '0;
            end
            valid_q <= '0;
            done_q  <= '0;
        end else if (en) begin
            for (int k = 0; k < DEPTH; k++) begin
                node_q[k] <= node_d[k];
            end
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Slice k-1 addresses the feature/threshold lookup for the comparison made at stage k.
    always_comb begin
        next_feature = '0;
        for (int k = 0; k < DEPTH-1; k++) begin
            next_feature[k*NODE_W +: NODE_W] = node_q[k];
        end
    end

    assign stage_valid  = valid_q;
    assign out_valid    = valid_q[DEPTH-1];
    assign out_early    = done_q[DEPTH-1] & valid_q[DEPTH-1];
    assign result_node  = node_q[DEPTH-1];
    assign leaf_offset  = node_q[DEPTH-1] - LEAF_BASE;
    assign result_index = (out_valid && !out_early) ? leaf_offset[DEPTH-1:0] : '0;

endmodule

// File: tb/tb_tree_pipe.sv
// Directed, table-driven bench for tree_pipe (DEPTH=10): a slot model tracks which sample sits in each
// stage so per-stage branch/leaf bits can be supplied, and every output is compared after each edge.
module tb_tree_pipe;

    localparam int DEPTH  = 10;
    localparam int NODE_W = 11;
    localparam int NVEC   = 13;

    logic                        clk;
    logic                        reset;
    logic                        en;
    logic                        flush;
    logic                        in_valid;
    logic [DEPTH-1:0]            next_branch;
    logic [DEPTH-1:0]            is_leaf;
    logic [(DEPTH-1)*NODE_W-1:0] next_feature;
    logic [DEPTH-1:0]            stage_valid;
    logic                        out_valid;
    logic                        out_early;
    logic [NODE_W-1:0]           result_node;
    logic [DEPTH-1:0]            result_index;

    typedef struct {
        logic [DEPTH-1:0] br;
        logic [DEPTH-1:0] lf;
        int               exp_node;
        logic             exp_early;
        int               exp_index;
    } vec_t;

    vec_t tbl [NVEC];
    int   slot [DEPTH];
    int   checks = 0;
    int   errors = 0;

    tree_pipe #(.DEPTH(DEPTH), .NODE_W(NODE_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .flush        (flush),
        .in_valid     (in_valid),
        .next_branch  (next_branch),
        .is_leaf      (is_leaf),
        .next_feature (next_feature),
        .stage_valid  (stage_valid),
        .out_valid    (out_valid),
        .out_early    (out_early),
        .result_node  (result_node),
        .result_index (result_index)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic check_eq(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Walk the tree from the root through levels 0..stage and return the node held after that stage.
    function automatic int ref_node(input int idx, input int stage);
        int node = 0;
        bit done = 1'b0;
        for (int l = 0; l <= stage; l++) begin
            if (!done) begin
                if (l < DEPTH-1 && tbl[idx].lf[l]) done = 1'b1;
                else node = 2*node + 1 + int'(tbl[idx].br[l]);
            end
        end
        return node;
    endfunction

    task automatic checkOutput(input string tag);
        logic [DEPTH-1:0] exp_sv;
        exp_sv = '0;
        for (int k = 0; k < DEPTH; k++) exp_sv[k] = (slot[k] >= 0);
        check_eq({tag, " stage_valid"}, int'(stage_valid), int'(exp_sv));
        check_eq({tag, " out_valid"}, int'(out_valid), int'(exp_sv[DEPTH-1]));
        for (int k = 0; k < DEPTH-1; k++) begin
            if (slot[k] >= 0)
                check_eq($sformatf("%s next_feature[%0d]", tag, k),
                         int'(next_feature[k*NODE_W +: NODE_W]), ref_node(slot[k], k));
        end
        if (slot[DEPTH-1] >= 0) begin
            check_eq($sformatf("%s result_node vec%0d", tag, slot[DEPTH-1]),
                     int'(result_node), tbl[slot[DEPTH-1]].exp_node);
            check_eq($sformatf("%s out_early vec%0d", tag, slot[DEPTH-1]),
                     int'(out_early), int'(tbl[slot[DEPTH-1]].exp_early));
            check_eq($sformatf("%s result_index vec%0d", tag, slot[DEPTH-1]),
                     int'(result_index), tbl[slot[DEPTH-1]].exp_index);
        end else begin
            check_eq({tag, " idle out_early"}, int'(out_early), 0);
            check_eq({tag, " idle result_index"}, int'(result_index), 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, " next_feature_any"}, int'(|next_feature), 0);
        check_eq({tag, " stage_valid"}, int'(stage_valid), 0);
        check_eq({tag, " out_valid"}, int'(out_valid), 0);
        check_eq({tag, " out_early"}, int'(out_early), 0);
        check_eq({tag, " result_node"}, int'(result_node), 0);
        check_eq({tag, " result_index"}, int'(result_index), 0);
    endtask

    // Drive one cycle: new_idx < 0 is a bubble; bits for stages without a sample are random.
    task automatic applyStimulus(input int new_idx, input logic en_v, input logic flush_v, input string tag);
        logic [DEPTH-1:0] nb, lf;
        nb = DEPTH'($urandom);
        lf = DEPTH'($urandom);
        if (new_idx >= 0) begin
            nb[0] = tbl[new_idx].br[0];
            lf[0] = tbl[new_idx].lf[0];
        end
        for (int k = 1; k < DEPTH; k++) begin
            if (slot[k-1] >= 0) begin
                nb[k] = tbl[slot[k-1]].br[k];
                lf[k] = tbl[slot[k-1]].lf[k];
            end
        end
        en          = en_v;
        flush       = flush_v;
        in_valid    = (new_idx >= 0);
        next_branch = nb;
        is_leaf     = lf;
        @(negedge clk);
        #1;
        if (en_v) begin
            if (flush_v) begin
                for (int k = 0; k < DEPTH; k++) slot[k] = -1;
            end else begin
                for (int k = DEPTH-1; k > 0; k--) slot[k] = slot[k-1];
                slot[0] = new_idx;
            end
        end
        checkOutput(tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH+1; i++) applyStimulus(-1, 1'b1, 1'b0, tag);
    endtask

    initial begin
        tbl[0]  = '{10'b0000000000, 10'b0000000000, 1023, 1'b0, 0};
        tbl[1]  = '{10'b1111111111, 10'b0000000000, 2046, 1'b0, 1023};
        tbl[2]  = '{10'b0101010101, 10'b0000000000, 1705, 1'b0, 682};
        tbl[3]  = '{10'b0000000101, 10'b0000001000, 12,   1'b1, 0};
        tbl[4]  = '{10'b1111111111, 10'b0000000001, 0,    1'b1, 0};
        tbl[5]  = '{10'b0000000000, 10'b1000000000, 1023, 1'b0, 0};
        tbl[6]  = '{10'b0000000001, 10'b0000000000, 1535, 1'b0, 512};
        tbl[7]  = '{10'b1000000000, 10'b0000000000, 1024, 1'b0, 1};
        tbl[8]  = '{10'b0000000000, 10'b0100000000, 255,  1'b1, 0};
        tbl[9]  = '{10'b1111111111, 10'b0000000010, 2,    1'b1, 0};
        tbl[10] = '{10'b0000000000, 10'b0000100100, 3,    1'b1, 0};
        tbl[11] = '{10'b0000111000, 10'b0000000000, 1135, 1'b0, 112};
        tbl[12] = '{10'b1010101010, 10'b0000000000, 1364, 1'b0, 341};

        for (int k = 0; k < DEPTH; k++) slot[k] = -1;
        reset       = 1'b0;
        en          = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        next_branch = '0;
        is_leaf     = '0;

        #2;
        check_all_zero("reset");
        @(negedge clk);
        #1;
        check_all_zero("reset_edge");
        reset = 1'b1;

        $display("[TB] single sample");
        applyStimulus(0, 1'b1, 1'b0, "single");
        drain("single");

        $display("[TB] back-to-back stream with one bubble");
        for (int i = 0; i < 10; i++) applyStimulus(i, 1'b1, 1'b0, "stream");
        applyStimulus(-1, 1'b1, 1'b0, "stream");
        applyStimulus(10, 1'b1, 1'b0, "stream");
        applyStimulus(11, 1'b1, 1'b0, "stream");
        applyStimulus(2, 1'b1, 1'b0, "stream");
        drain("stream");

        $display("[TB] shallow leaf at level 3");
        applyStimulus(3, 1'b1, 1'b0, "leaf");
        check_eq("leaf slice0", int'(next_feature[0*NODE_W +: NODE_W]), 2);
        applyStimulus(-1, 1'b1, 1'b0, "leaf");
        check_eq("leaf slice1", int'(next_feature[1*NODE_W +: NODE_W]), 5);
        applyStimulus(-1, 1'b1, 1'b0, "leaf");
        check_eq("leaf slice2", int'(next_feature[2*NODE_W +: NODE_W]), 12);
        drain("leaf");

        $display("[TB] stall then flush");
        applyStimulus(1, 1'b1, 1'b0, "stall");
        applyStimulus(12, 1'b1, 1'b0, "stall");
        applyStimulus(5, 1'b1, 1'b0, "stall");
        for (int i = 0; i < 3; i++) applyStimulus(4, 1'b0, 1'b1, "stall_hold");
        applyStimulus(4, 1'b1, 1'b1, "flush");
        check_eq("flush stage_valid", int'(stage_valid), 0);
        applyStimulus(0, 1'b1, 1'b0, "post_flush");
        check_eq("post_flush stage_valid", int'(stage_valid), 1);
        drain("post_flush");

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 5; i++) applyStimulus(i, 1'b1, 1'b0, "pre_reset");
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        for (int k = 0; k < DEPTH; k++) slot[k] = -1;
        @(negedge clk);
        #1;
        check_all_zero("async_reset_edge");
        reset = 1'b1;
        applyStimulus(-1, 1'b1, 1'b0, "post_reset");
        applyStimulus(-1, 1'b1, 1'b0, "post_reset");
        applyStimulus(6, 1'b1, 1'b0, "post_reset");
        drain("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
